// File: rtl/wb_periph_decoder.sv
// wb_periph_decoder: routes Wishbone transfers to one of NUM_SLAVES windows with a timeout.
// Define WB_PERIPH_DECODER_IRQ_EN for a sticky error interrupt on irq_o.
module wb_periph_decoder #(
  parameter int          NUM_SLAVES = 4,
  parameter logic [31:0] ADDR_BASE  = 32'h3000_0000,
  parameter int          SLOT_BITS  = 16,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  output logic [NUM_SLAVES-1:0]    s_cyc_o,
  output logic [NUM_SLAVES-1:0]    s_stb_o,
  output logic                     s_we_o,
  output logic [3:0]               s_sel_o,
  output logic [31:0]              s_adr_o,
  output logic [31:0]              s_dat_o,
  input  logic [32*NUM_SLAVES-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]    s_ack_i,
  output logic                     err_o,
  output logic                     irq_o,
  input  logic                     irq_clr_i
);
  localparam int IW = $clog2(NUM_SLAVES);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int HB = SLOT_BITS + IW;
  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;
  state_t state;
  logic [IW-1:0] idx, a_idx;
  logic [CW-1:0] cnt;
  logic hit, ack, tmo;
  always_comb begin
    a_idx = wbs_adr_i[HB-1:SLOT_BITS];
    hit = (wbs_adr_i[31:HB] == ADDR_BASE[31:HB]) && (32'(a_idx) < NUM_SLAVES);
    ack = s_ack_i[idx];
    tmo = cnt == CW'(TIMEOUT - 1);
  end
  assign s_stb_o = s_cyc_o;
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      s_cyc_o   <= '0;
      s_we_o    <= 1'b0;
      s_sel_o   <= '0;
      s_adr_o   <= '0;
      s_dat_o   <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      err_o     <= 1'b0;
    end else begin
      err_o     <= 1'b0;
      wbs_ack_o <= 1'b0;
      case (state)
        IDLE: if (wbs_cyc_i && wbs_stb_i) begin
          s_we_o  <= wbs_we_i;
          s_sel_o <= wbs_sel_i;
          s_adr_o <= wbs_adr_i;
          s_dat_o <= wbs_dat_i;
          idx     <= a_idx;
          cnt     <= '0;
          if (hit) begin
            s_cyc_o <= NUM_SLAVES'(1) << a_idx;
            state   <= ACTIVE;
          end else begin
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= ERR_DATA;
            err_o     <= 1'b1;
            state     <= RESP;
          end
        end
        ACTIVE: begin
          cnt <= cnt + 1'b1;
          if (!wbs_cyc_i) begin
            s_cyc_o <= '0;
            cnt     <= '0;
            state   <= IDLE;
          end else if (ack || tmo) begin
            // an ack arriving on the timeout cycle still counts as a good transfer
            s_cyc_o   <= '0;
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= ack ? (s_we_o ? '0 : s_dat_i[32*idx +: 32]) : ERR_DATA;
            err_o     <= !ack;
            state     <= RESP;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
`ifdef WB_PERIPH_DECODER_IRQ_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) irq_o <= 1'b0;
    else irq_o <= err_o | (irq_o & ~irq_clr_i);
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr_i;
  assign irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_wb_periph_decoder.sv
// tb_wb_periph_decoder: directed scoreboard bench for wb_periph_decoder with TIMEOUT=8.
module tb_wb_periph_decoder;
`ifdef WB_PERIPH_DECODER_IRQ_EN
  localparam logic IRQ = 1'b1;
`else
  localparam logic IRQ = 1'b0;
`endif
  logic clk = 0, rst_n = 0;
  logic cyc = 0, stb = 0, we = 0, irq_clr = 0;
  logic [3:0] sel = 0;
  logic [31:0] adr = 0, dat = 0;
  logic wbs_ack_o, s_we_o, err_o, irq_o;
  logic [31:0] wbs_dat_o, s_adr_o, s_dat_o;
  logic [3:0] s_cyc_o, s_stb_o, s_sel_o, s_ack;
  logic [127:0] s_dat_i;
  logic [31:0] rdata [4];
  int ack_at [4];
  int scnt [4];
  int checks = 0, errors = 0, stb_cycles = 0;
  logic [32:0] exp_q [$];
  logic [32:0] e;

  always #5 clk = ~clk;

  wb_periph_decoder #(.TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack), .err_o(err_o), .irq_o(irq_o),
    .irq_clr_i(irq_clr)
  );

  for (genvar g = 0; g < 4; g++) assign s_dat_i[32*g +: 32] = rdata[g];

  // slaves register their ack: ack_at strobed cycles of wait, then a one-cycle ack
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_ack <= '0;
      for (int k = 0; k < 4; k++) scnt[k] <= 0;
    end else
      for (int k = 0; k < 4; k++)
        if (s_stb_o[k] && !s_ack[k]) begin
          if (scnt[k] == ack_at[k]) s_ack[k] <= 1'b1;
          else scnt[k] <= scnt[k] + 1;
        end else begin
          s_ack[k] <= 1'b0;
          scnt[k]  <= 0;
        end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (|s_stb_o) stb_cycles++;
    if (rst_n && wbs_ack_o) begin
      if (exp_q.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("rdata", wbs_dat_o, e[31:0]);
        chk("err_at_ack", {31'd0, err_o}, {31'd0, e[32]});
      end
    end
  end

  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] exp_d, input logic exp_e, input int exp_lat, input logic [3:0] exp_stb);
    int n = 0;
    exp_q.push_back({exp_e, exp_d});
    cyc = 1; stb = 1; we = w; adr = a; dat = d; sel = s;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        chk("s_stb", {28'd0, s_stb_o}, {28'd0, exp_stb});
        chk("s_cyc", {28'd0, s_cyc_o}, {28'd0, exp_stb});
        chk("s_adr", s_adr_o, a);
        chk("s_dat", s_dat_o, d);
        chk("s_sel_we", {27'd0, s_sel_o, s_we_o}, {27'd0, s, w});
      end
    end while (!wbs_ack_o && n < 40);
    chk("latency", n, exp_lat);
    cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1;
    chk("ack_one_cycle", {31'd0, wbs_ack_o}, 32'd0);
    chk("err_one_cycle", {31'd0, err_o}, 32'd0);
    chk("dat_held", wbs_dat_o, exp_d);
  endtask

  initial begin
    int st;
    for (int k = 0; k < 4; k++) begin rdata[k] = 32'h0; ack_at[k] = 0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
    chk("rst_dat", wbs_dat_o, 32'd0);
    chk("rst_cyc_stb", {24'd0, s_cyc_o, s_stb_o}, 32'd0);
    chk("rst_s_regs", s_adr_o | s_dat_o | {27'd0, s_sel_o, s_we_o}, 32'd0);
    chk("rst_err_irq", {30'd0, err_o, irq_o}, 32'd0);
    rst_n = 1;
    rdata[1] = 32'h1234_5678;
    st = stb_cycles;
    req(0, 32'h3001_0004, 32'h0, 4'hF, 32'h1234_5678, 0, 3, 4'b0010);
    chk("hit_stb_cycles", stb_cycles - st, 2);
    rdata[3] = 32'hFFFF_FFFF;
    req(1, 32'h3003_0000, 32'hA5A5_A5A5, 4'b0011, 32'h0, 0, 3, 4'b1000);
    rdata[0] = 32'h0BAD_F00D; ack_at[0] = 2;
    req(0, 32'h3000_FFFC, 32'h0, 4'hF, 32'h0BAD_F00D, 0, 5, 4'b0001);
    req(0, 32'h4000_0000, 32'h0, 4'hF, 32'hDEAD_BEEF, 1, 1, 4'b0000);
    chk("irq_after_miss", {31'd0, irq_o}, {31'd0, IRQ});
    irq_clr = 1;
    @(posedge clk); #1;
    irq_clr = 0;
    chk("irq_cleared", {31'd0, irq_o}, 32'd0);
    req(0, 32'h3004_0000, 32'h0, 4'hF, 32'hDEAD_BEEF, 1, 1, 4'b0000);
    irq_clr = 1;
    @(posedge clk); #1;
    irq_clr = 0;
    ack_at[2] = 255;
    st = stb_cycles;
    req(0, 32'h3002_0010, 32'h0, 4'hF, 32'hDEAD_BEEF, 1, 9, 4'b0100);
    chk("timeout_stb_cycles", stb_cycles - st, 8);
    chk("irq_after_timeout", {31'd0, irq_o}, {31'd0, IRQ});
    rdata[0] = 32'hCAFE_0000; ack_at[0] = 6;
    req(0, 32'h3000_0000, 32'h0, 4'hF, 32'hCAFE_0000, 0, 9, 4'b0001);
    cyc = 1; stb = 1; adr = 32'h3002_0000;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_active", {28'd0, s_cyc_o}, 32'd4);
    cyc = 0; stb = 0;
    @(posedge clk); #1;
    chk("abort_cyc_drop", {28'd0, s_cyc_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_ack_err", {30'd0, wbs_ack_o, err_o}, 32'd0);
      @(posedge clk); #1;
    end
    ack_at[1] = 255;
    cyc = 1; stb = 1; adr = 32'h3001_0000;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    chk("rst_mid_cyc", {28'd0, s_cyc_o}, 32'd0);
    chk("rst_mid_ack_irq", {30'd0, wbs_ack_o, irq_o}, 32'd0);
    cyc = 0; stb = 0;
    @(posedge clk); #1;
    rst_n = 1;
    ack_at[1] = 0; rdata[1] = 32'h5555_AAAA;
    req(0, 32'h3001_0008, 32'h0, 4'hF, 32'h5555_AAAA, 0, 3, 4'b0010);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
